// File: rtl/clk_div_pkg.sv
// Shared constants and state type for the programmable 50%-duty clock divider.
package clk_div_pkg;
  localparam int CNT_W_DEFAULT   = 8;
  localparam int DIV_MIN         = 2;
  localparam int DEF_DIV_DEFAULT = 9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;
endpackage

// File: rtl/clk_div_negcap.sv
// Falling-edge retime flop; its async reset lets a reset drop clk_div mid negedge half.
module clk_div_negcap (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  always_ff @(negedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end
endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider: 50% duty for any N >= 2, boundary-aligned divisor updates.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             clk_div,
  output logic             tick,
  output logic             div_pend,
  output logic             div_err
);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DIV_LO  = CNT_W'(DIV_MIN);

  run_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] div_act, div_act_nxt;
  logic [CNT_W-1:0] div_pnd, div_pnd_nxt;
  logic             pend_nxt, err_nxt, tick_nxt;
  logic             p, p_nxt, n;
  logic             load_ok, wrap, run_nxt;

  assign load_ok = div_load && (div_in >= DIV_LO);
  assign wrap    = (cnt == (div_act - CNT_W'(1)));

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    div_act_nxt = div_act;
    div_pnd_nxt = div_pnd;
    pend_nxt    = div_pend;
    err_nxt     = div_err;
    if (div_load) err_nxt = !load_ok;
    case (state)
      ST_RUN: begin
        if (wrap) begin
          cnt_nxt   = '0;
          state_nxt = en ? ST_RUN : ST_IDLE;
          // A load landing on the last count of a period takes effect right here.
          if (load_ok) begin
            div_act_nxt = div_in;
            pend_nxt    = 1'b0;
          end else if (div_pend) begin
            div_act_nxt = div_pnd;
            pend_nxt    = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if (load_ok) begin
            div_pnd_nxt = div_in;
            pend_nxt    = 1'b1;
          end
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = en ? ST_RUN : ST_IDLE;
        if (div_pend) begin
          div_act_nxt = div_pnd;
          pend_nxt    = 1'b0;
        end
        if (load_ok) begin
          div_pnd_nxt = div_in;
          pend_nxt    = 1'b1;
        end
      end
    endcase
    run_nxt  = (state_nxt == ST_RUN);
    p_nxt    = run_nxt && (cnt_nxt < (div_act_nxt >> 1));
    tick_nxt = run_nxt && (cnt_nxt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      div_act  <= DIV_RST;
      div_pend <= 1'b0;
      div_err  <= 1'b0;
      p        <= 1'b0;
      tick     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      div_act  <= div_act_nxt;
      div_pend <= pend_nxt;
      div_err  <= err_nxt;
      p        <= p_nxt;
      tick     <= tick_nxt;
    end
  end

  // Pending value is only ever consumed while div_pend is set, so it needs no reset.
  always_ff @(posedge clk) begin
    div_pnd <= div_pnd_nxt;
  end

  clk_div_negcap u_negcap (
    .clk (clk),
    .rst (rst),
    .d   (p),
    .q   (n)
  );

  // n is low at every period boundary, so switching parity there cannot glitch.
  assign clk_div = p | (div_act[0] & n);
endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning counter/divisor width in bits.
REQ-002 SHALL have parameter DEF_DIV, default 9, meaning divisor loaded at reset; legal range 2..2^CNT_W-1.
REQ-003 SHALL have port clk  input  1  sole clock; both edges are used.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  divider run enable.
REQ-006 SHALL have port div_in  input  CNT_W  requested divisor N.
REQ-007 SHALL have port div_load  input  1  one-cycle strobe that captures div_in.
REQ-008 SHALL have port clk_div  output  1  divided clock, 50% duty for even and odd N.
REQ-009 SHALL have port tick  output  1  one-clk pulse marking the start of each clk_div period.
REQ-010 SHALL have port div_pend  output  1  a captured divisor is waiting for a period boundary.
REQ-011 SHALL have port div_err  output  1  sticky flag: last div_load carried an illegal divisor.

Function
REQ-012 SHALL run a posedge counter cnt over 0..N-1, where N is the active divisor, and wrap from N-1 to 0 (the period boundary).
REQ-013 SHALL define H = floor(N/2); posedge flag p SHALL be high for cnt values 0..H-1 and registered so it is glitch-free.
REQ-014 SHALL produce negedge flag n as p retimed on the falling edge of clk.
REQ-015 SHALL drive clk_div = p OR n for odd N, giving H+0.5 clk high and H+0.5 clk low; for even N it SHALL drive clk_div = p, giving N/2 high and N/2 low.
REQ-016 SHALL assert tick for exactly one clk cycle, coincident with cnt==0, while running.
REQ-017 SHALL capture div_in into a pending register on div_load when 2 <= div_in; it SHALL set div_pend and clear div_err.
REQ-018 SHALL ignore div_load with div_in < 2, leave the active and pending divisors unchanged, and set div_err.
REQ-019 SHALL transfer the pending divisor to active only at a period boundary, or on the next clk when idle; div_pend SHALL clear in the same cycle.
REQ-020 SHALL apply a valid div_load sampled in the cycle where cnt==N-1 at that boundary.
REQ-021 SHALL let a later div_load overwrite an earlier pending value (last-wins).
REQ-022 SHALL, when en falls mid-period, finish the current period, then hold cnt=0 and clk_div=0 (idle) with no runt pulse.
REQ-023 SHALL, when en rises from idle, start a full-length period with clk_div rising on the first clk posedge.
REQ-024 SHALL drive no runt or glitch on clk_div across divisor changes or en changes.

Reset
REQ-025 SHALL, while rst is high, asynchronously force cnt=0, p=0, n=0, clk_div=0, tick=0, div_pend=0, div_err=0, and active divisor=DEF_DIV.
REQ-026 SHALL apply reset to the negedge flop n as well as to the posedge state, so a reset arriving during a high phase drops clk_div immediately.
REQ-027 SHALL resume after reset release only when en is high, starting at cnt=0.

Structure
REQ-028 SHALL place CNT_W default, DIV_MIN=2 and DEF_DIV in shared package clk_div_pkg.
REQ-029 SHALL isolate the falling-edge retime flop, with its async reset, in sub-module clk_div_negcap.

Verification
REQ-030 Scenario: N=9, en=1 -> clk_div period 9 clk, high 4.5 clk, low 4.5 clk; tick every 9 clk.
REQ-031 Scenario: load 4 while idle, then en=1 -> clk_div high 2 clk, low 2 clk; tick every 4 clk.
REQ-032 Scenario: N=9 running, load 5 at cnt=3 -> div_pend=1, the 9-cycle period completes, then 5-cycle periods follow (high 2.5 clk); div_pend=0 at the boundary.
REQ-033 Scenario: div_load with div_in=1 -> div_err=1, period unchanged; a subsequent load of 6 clears div_err.
REQ-034 Scenario: en drops at cnt=2 of N=7 -> the period completes, then clk_div stays 0 and tick stays 0.
REQ-035 Scenario: rst pulsed during the high phase of clk_div, including in the negedge half -> clk_div=0 with no clock edge; after release with en=1, the first period has N=DEF_DIV.
